// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants and divisor helper for the UART baud tick logic.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned OS_DEFAULT = 16;
    localparam int unsigned MIN_DIV    = 2;
    localparam int unsigned FRAC_W     = 8;

    // Integer prescale divisor, rounded down.
    function automatic int unsigned calc_div(
        input int unsigned clk_hz,
        input int unsigned baud,
        input int unsigned os
    );
        return clk_hz / (baud * os);
    endfunction

endpackage
`default_nettype wire

// File: rtl/baud_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : baud_prescaler
// Purpose  : Divide-by-D prescaler with shadowed divisor, emits rx_tick.
//            Optional fractional divisor under BAUD_FRAC_DIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module baud_prescaler
    import uart_pkg::*;
#(
    parameter int          DIV_W     = 16,
    parameter int unsigned RESET_DIV = 54
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             restart,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
`ifdef BAUD_FRAC_DIV_EN
    input  logic [FRAC_W-1:0] div_frac,
`endif
    output logic             rx_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_div_shd;
    logic             r_tick;
    logic [DIV_W-1:0] w_lim;
    logic             w_wrap;
    logic             w_load_ok;

    assign w_load_ok = div_load && (div_value >= DIV_W'(MIN_DIV));
    // ">=" rather than "==" so a divisor shrunk while frozen cannot strand the count.
    assign w_wrap    = (r_cnt >= w_lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_div_act <= DIV_W'(RESET_DIV);
            r_div_shd <= DIV_W'(RESET_DIV);
        end else begin
            if (w_load_ok) begin
                r_div_shd <= div_value;
            end
            if (restart) begin
                r_cnt     <= '0;
                r_tick    <= 1'b0;
                r_div_act <= r_div_shd;
            end else if (!enable) begin
                r_tick    <= 1'b0;
                r_div_act <= r_div_shd;
            end else if (w_wrap) begin
                r_cnt     <= '0;
                r_tick    <= 1'b1;
                r_div_act <= r_div_shd;
            end else begin
                r_cnt     <= r_cnt + DIV_W'(1);
                r_tick    <= 1'b0;
            end
        end
    end

`ifdef BAUD_FRAC_DIV_EN
    logic [FRAC_W-1:0] r_frac_shd;
    logic [FRAC_W-1:0] r_frac_act;
    logic [FRAC_W-1:0] r_acc;
    logic              r_extend;

    // Carry out of the phase accumulator stretches the next period by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frac_shd <= '0;
            r_frac_act <= '0;
            r_acc      <= '0;
            r_extend   <= 1'b0;
        end else begin
            if (w_load_ok) begin
                r_frac_shd <= div_frac;
            end
            if (restart) begin
                r_acc      <= '0;
                r_extend   <= 1'b0;
                r_frac_act <= r_frac_shd;
            end else if (!enable) begin
                r_frac_act <= r_frac_shd;
            end else if (w_wrap) begin
                {r_extend, r_acc} <= {1'b0, r_acc} + {1'b0, r_frac_act};
                r_frac_act        <= r_frac_shd;
            end
        end
    end

    assign w_lim = r_div_act - DIV_W'(1) + DIV_W'(r_extend);
`else
    assign w_lim = r_div_act - DIV_W'(1);
`endif

    // A registered tick is dropped in any cycle that is held, restarted or reset.
    assign rx_tick = r_tick && enable && !restart && !rst;

endmodule
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_gen
// Purpose  : UART rx oversample / tx bit clock-enable generator.
//            Optional fractional divisor input enabled by BAUD_FRAC_DIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = OS_DEFAULT,
    parameter int          DIV_W      = 16,
    parameter int unsigned RESET_DIV  = calc_div(CLK_HZ, BAUD, OVERSAMPLE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          restart,
    input  logic                          div_load,
    input  logic [DIV_W-1:0]              div_value,
`ifdef BAUD_FRAC_DIV_EN
    input  logic [FRAC_W-1:0]             div_frac,
`endif
    output logic                          div_err,
    output logic                          rx_tick,
    output logic                          tx_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int                 c_PH_W    = $clog2(OVERSAMPLE);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(OVERSAMPLE - 1);

    logic              w_rx_tick;
    logic [c_PH_W-1:0] r_phase;
    logic              r_div_err;

    baud_prescaler #(
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .restart   (restart),
        .div_load  (div_load),
        .div_value (div_value),
`ifdef BAUD_FRAC_DIV_EN
        .div_frac  (div_frac),
`endif
        .rx_tick   (w_rx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= '0;
            r_div_err <= 1'b0;
        end else begin
            r_div_err <= div_load && (div_value < DIV_W'(MIN_DIV));
            if (restart) begin
                r_phase <= '0;
            end else if (w_rx_tick) begin
                r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + c_PH_W'(1);
            end
        end
    end

    assign rx_tick  = w_rx_tick;
    assign tx_tick  = w_rx_tick && (r_phase == c_PH_LAST);
    assign os_phase = r_phase;
    assign div_err  = r_div_err;

endmodule
`default_nettype wire
